datapath_bus_unit: RTL and testbench
====================================

Name: datapath_bus_unit

Overview:
- Datapath-side responder to the processor control FSM.
- Each cycle it decodes the bus-source select, the write/increment/clear strobes and the ALU opcode. It updates the architectural registers (PC, AR, IR, AC, R, R1-R4, DR) and drives the data/instruction memory ports.
- It returns the current opcode and the zero flag to the control FSM.
- Sits between the control FSM and the DM/IM memories.

Parameters:
- DATA_W, 16: width of the bus and of every register.
- ADDR_W, 8: width of dm_addr and im_addr (low bits of AR/PC).
- OPC_W, 6: width of the opcode field taken from IR[OPC_W-1:0].

Ports:
- clk  in  1  system clock; all registers update on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- read_en  in  4  bus-source select code.
- write_en  in  16  register/memory write strobes.
- inc_en  in  16  increment strobes.
- clr_en  in  16  clear strobes.
- alu_op  in  3  ALU operation.
- halt  in  1  end_process from control; freezes the datapath.
- dm_rdata  in  DATA_W  data memory read data.
- im_rdata  in  DATA_W  instruction memory read data.
- dm_addr  out  ADDR_W  AR[ADDR_W-1:0].
- dm_wdata  out  DATA_W  current bus value.
- dm_we  out  1  data memory write strobe.
- im_addr  out  ADDR_W  PC[ADDR_W-1:0].
- instruction  out  OPC_W  IR[OPC_W-1:0], combinational from IR.
- z  out  16  {15'b0, AC==0}, combinational.
- bus_dbg  out  DATA_W  current bus value, for debug.

Behaviour:
- Reset (async, rst=1): PC, AR, IR, AC, R, R1-R4, DR are all 0.
  - Consequences: im_addr=0, dm_addr=0, instruction=0, z=16'h0001, dm_we=0.
- Bus mux is combinational on read_en:
  - 0 -> 0
  - 1 -> PC
  - 2 -> AR
  - 3 -> DR
  - 4 -> IR
  - 5 -> AC
  - 6 -> R
  - 7 -> R1, 8 -> R2, 9 -> R3, 10 -> R4
  - 11 -> DR
  - 12 -> dm_rdata
  - 13 -> im_rdata
  - 14, 15 -> 0
- Strobe bit map. write_en:
  - 1 PC, 2 AR, 3 IR, 4 AC (from bus), 5 R
  - 7 R4, 8 R3, 9 R2, 10 R1
  - 11 DM (dm_we), 12 AC from ALU
  - other bits ignored
- inc_en: bit1 PC, bit4 AC; other bits ignored.
- clr_en: bit1 PC, bit2 AR, bit4 AC; other bits ignored.
- Per-register priority at a clock edge: clear > write > increment.
  - Example: write_en[1] and inc_en[1] together -> PC = bus (jump wins over increment).
- AC source priority: write_en[12] (ALU) beats write_en[4] (bus).
- ALU is combinational; the result is captured into AC only when write_en[12]=1:
  - 1: AC+R
  - 2: AC-R
  - 3: low DATA_W bits of AC*R
  - 4: AC << R[3:0]
  - 0, 5-7: AC (no change)
- Arithmetic wraps modulo 2^DATA_W, including PC and AC increment (0xFFFF + 1 = 0). No carry/overflow flag.
- Write latency:
  - A register written in cycle n shows its new value after the rising edge ending cycle n.
  - instruction and z reflect it in the same cycle after that edge, in time for the control FSM's falling-edge state update.
- dm_we is combinational: write_en[11] & ~halt. dm_wdata is the bus in the same cycle.
  - DM is required to capture on the rising edge.
- halt=1: all register updates and dm_we are suppressed; outputs hold. Reset still overrides.
- Reset asserted mid-instruction: all registers clear immediately, independent of clk.
- After reset release, the first rising edge obeys the strobes present at that edge.

Decomposition:
- Shared package dp_pkg holds:
  - read_en source codes (SRC_NONE..SRC_IM)
  - write/inc/clr bit indices (BIT_PC, BIT_AR, BIT_IR, BIT_AC, BIT_R, BIT_R1..BIT_R4, BIT_DM, BIT_ALU_AC)
  - ALU opcodes (ALU_NOP, ALU_ADD, ALU_SUB, ALU_MUL, ALU_SHL)
- One sub-module, dp_alu: combinational ALU, ports ac, r, alu_op, result.
- The control FSM imports the same package so encodings cannot drift.

Test Plan:
- Reset then fetch:
  - Stimulus: rst pulse, then clr_en=0x0006, then read_en=13, write_en=0x0008, im_rdata=0x0013.
  - Required: PC=0, AR=0, IR=0x0013, instruction=6'h13, z=1.
- Load and move:
  - Stimulus: AC=0 (after reset); read_en=5, write_en=0x0004; then read_en=12, dm_rdata=0x0007, write_en=0x0010, inc_en=0x0002.
  - Required: AR=0, AC=7, PC incremented by 1, z=0.
- ALU:
  - Stimulus: AC=7, R=3; alu_op=1, write_en=0x1000. Then alu_op=2 with R=10. Then alu_op=3 with AC=0x0100, R=0x0100.
  - Required: AC=10. Then AC=0 and z=1. Then AC=0x0000 (truncated product).
- Jump priority:
  - Stimulus: IR=0x0040, PC=5; read_en=4, write_en=0x0002, inc_en=0x0002.
  - Required: PC=0x0040, not 0x0041.
- DM store and halt:
  - Stimulus: AC=0x1234, AR=9; read_en=5, write_en=0x0800. Then halt=1 with write_en=0x0010, inc_en=0x0012.
  - Required: dm_we=1, dm_addr=9, dm_wdata=0x1234. Under halt: dm_we=0, AC and PC unchanged.
- Async reset mid-operation:
  - Stimulus: AC=0xFFFF, inc_en=0x0010 for one edge; then rst asserted between edges.
  - Required: AC wraps to 0, z=1. All registers read 0 before the next clk edge.

Source files
------------

// File: rtl/datapath_bus_unit_pkg.sv
// Shared encodings for the datapath and the control FSM: bus-source codes,
// strobe bit positions and ALU opcodes.
package dp_pkg;

    localparam int unsigned STROBE_W = 16;

    // read_en bus-source select codes
    typedef enum logic [3:0] {
        SRC_NONE   = 4'd0,
        SRC_PC     = 4'd1,
        SRC_AR     = 4'd2,
        SRC_DR     = 4'd3,
        SRC_IR     = 4'd4,
        SRC_AC     = 4'd5,
        SRC_R      = 4'd6,
        SRC_R1     = 4'd7,
        SRC_R2     = 4'd8,
        SRC_R3     = 4'd9,
        SRC_R4     = 4'd10,
        SRC_DR_ALT = 4'd11,
        SRC_DM     = 4'd12,
        SRC_IM     = 4'd13
    } src_e;

    // Bit positions inside write_en / inc_en / clr_en
    localparam int unsigned BIT_PC     = 1;
    localparam int unsigned BIT_AR     = 2;
    localparam int unsigned BIT_IR     = 3;
    localparam int unsigned BIT_AC     = 4;
    localparam int unsigned BIT_R      = 5;
    localparam int unsigned BIT_R4     = 7;
    localparam int unsigned BIT_R3     = 8;
    localparam int unsigned BIT_R2     = 9;
    localparam int unsigned BIT_R1     = 10;
    localparam int unsigned BIT_DM     = 11;
    localparam int unsigned BIT_ALU_AC = 12;

    // ALU operations; unlisted codes pass AC through
    typedef enum logic [2:0] {
        ALU_NOP = 3'd0,
        ALU_ADD = 3'd1,
        ALU_SUB = 3'd2,
        ALU_MUL = 3'd3,
        ALU_SHL = 3'd4
    } alu_op_e;

endpackage

// File: rtl/datapath_bus_unit_if.sv
// Control/memory-side signal bundle of the datapath. The control FSM (and
// memories) sit on the master side, the datapath on the slave side.
interface datapath_bus_unit_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OPC_W  = 6
) ();
    logic [3:0]        read_en;
    logic [15:0]       write_en;
    logic [15:0]       inc_en;
    logic [15:0]       clr_en;
    logic [2:0]        alu_op;
    logic              halt;
    logic [DATA_W-1:0] dm_rdata;
    logic [DATA_W-1:0] im_rdata;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_we;
    logic [ADDR_W-1:0] im_addr;
    logic [OPC_W-1:0]  instruction;
    logic [15:0]       z;
    logic [DATA_W-1:0] bus_dbg;

    modport master (
        output read_en, write_en, inc_en, clr_en, alu_op, halt, dm_rdata, im_rdata,
        input  dm_addr, dm_wdata, dm_we, im_addr, instruction, z, bus_dbg
    );

    modport slave (
        input  read_en, write_en, inc_en, clr_en, alu_op, halt, dm_rdata, im_rdata,
        output dm_addr, dm_wdata, dm_we, im_addr, instruction, z, bus_dbg
    );
endinterface

// File: rtl/datapath_bus_unit_alu.sv
// Combinational ALU. Results wrap modulo 2^DATA_W; no flags are produced.
module dp_alu
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16
) (
    input  logic [DATA_W-1:0] ac,
    input  logic [DATA_W-1:0] r,
    input  logic [2:0]        alu_op,
    output logic [DATA_W-1:0] result
);

    // Operation select; multiply keeps only the low DATA_W bits
    always_comb begin
        result = ac;
        case (alu_op)
            ALU_ADD: result = ac + r;
            ALU_SUB: result = ac - r;
            ALU_MUL: result = ac * r;
            ALU_SHL: result = ac << r[3:0];
            default: result = ac;
        endcase
    end

endmodule

// File: rtl/datapath_bus_unit.sv
// Datapath responder to the control FSM: bus mux, architectural registers,
// ALU hookup and DM/IM port drive. halt freezes every register and dm_we.
module datapath_bus_unit
    import dp_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned OPC_W  = 6
) (
    input logic                clk,
    input logic                rst,
    datapath_bus_unit_if.slave bus
);

    logic [DATA_W-1:0] pc_q, pc_d;
    logic [DATA_W-1:0] ar_q, ar_d;
    logic [DATA_W-1:0] ir_q, ir_d;
    logic [DATA_W-1:0] ac_q, ac_d;
    logic [DATA_W-1:0] dr_q, dr_d;
    logic [DATA_W-1:0] r_q,  r_d;
    logic [DATA_W-1:0] r1_q, r1_d;
    logic [DATA_W-1:0] r2_q, r2_d;
    logic [DATA_W-1:0] r3_q, r3_d;
    logic [DATA_W-1:0] r4_q, r4_d;

    logic [DATA_W-1:0] bus_val;
    logic [DATA_W-1:0] alu_res;

    // Strobe bits with no assigned register are deliberately ignored
    logic unused_strobes;
    assign unused_strobes = ^{bus.write_en[15:13], bus.write_en[6], bus.write_en[0],
                              bus.inc_en[15:5], bus.inc_en[3:2], bus.inc_en[0],
                              bus.clr_en[15:5], bus.clr_en[3], bus.clr_en[0]};

    // Bus source multiplexer
    always_comb begin
        bus_val = '0;
        case (bus.read_en)
            SRC_PC:     bus_val = pc_q;
            SRC_AR:     bus_val = ar_q;
            SRC_DR:     bus_val = dr_q;
            SRC_IR:     bus_val = ir_q;
            SRC_AC:     bus_val = ac_q;
            SRC_R:      bus_val = r_q;
            SRC_R1:     bus_val = r1_q;
            SRC_R2:     bus_val = r2_q;
            SRC_R3:     bus_val = r3_q;
            SRC_R4:     bus_val = r4_q;
            SRC_DR_ALT: bus_val = dr_q;
            SRC_DM:     bus_val = bus.dm_rdata;
            SRC_IM:     bus_val = bus.im_rdata;
            default:    bus_val = '0;
        endcase
    end

    dp_alu #(.DATA_W(DATA_W)) u_alu (
        .ac     (ac_q),
        .r      (r_q),
        .alu_op (bus.alu_op),
        .result (alu_res)
    );

    // Next-state: clear beats write beats increment; ALU write beats bus write for AC
    always_comb begin
        pc_d = pc_q;
        ar_d = ar_q;
        ir_d = ir_q;
        ac_d = ac_q;
        dr_d = dr_q;
        r_d  = r_q;
        r1_d = r1_q;
        r2_d = r2_q;
        r3_d = r3_q;
        r4_d = r4_q;
        if (!bus.halt) begin
            if (bus.clr_en[BIT_PC])        pc_d = '0;
            else if (bus.write_en[BIT_PC]) pc_d = bus_val;
            else if (bus.inc_en[BIT_PC])   pc_d = pc_q + DATA_W'(1);

            if (bus.clr_en[BIT_AR])        ar_d = '0;
            else if (bus.write_en[BIT_AR]) ar_d = bus_val;

            if (bus.write_en[BIT_IR])      ir_d = bus_val;

            if (bus.clr_en[BIT_AC])            ac_d = '0;
            else if (bus.write_en[BIT_ALU_AC]) ac_d = alu_res;
            else if (bus.write_en[BIT_AC])     ac_d = bus_val;
            else if (bus.inc_en[BIT_AC])       ac_d = ac_q + DATA_W'(1);

            if (bus.write_en[BIT_R])  r_d  = bus_val;
            if (bus.write_en[BIT_R1]) r1_d = bus_val;
            if (bus.write_en[BIT_R2]) r2_d = bus_val;
            if (bus.write_en[BIT_R3]) r3_d = bus_val;
            if (bus.write_en[BIT_R4]) r4_d = bus_val;
        end
    end

    // Architectural registers; reset clears them immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc_q <= '0;
            ar_q <= '0;
            ir_q <= '0;
            ac_q <= '0;
            dr_q <= '0;
            r_q  <= '0;
            r1_q <= '0;
            r2_q <= '0;
            r3_q <= '0;
            r4_q <= '0;
        end else begin
            pc_q <= pc_d;
            ar_q <= ar_d;
            ir_q <= ir_d;
            ac_q <= ac_d;
            dr_q <= dr_d;
            r_q  <= r_d;
            r1_q <= r1_d;
            r2_q <= r2_d;
            r3_q <= r3_d;
            r4_q <= r4_d;
        end
    end

    // Memory ports and status back to the control FSM
    assign bus.dm_addr     = ar_q[ADDR_W-1:0];
    assign bus.im_addr     = pc_q[ADDR_W-1:0];
    assign bus.dm_wdata    = bus_val;
    assign bus.dm_we       = bus.write_en[BIT_DM] & ~bus.halt;
    assign bus.instruction = ir_q[OPC_W-1:0];
    assign bus.z           = {15'b0, (ac_q == '0)};
    assign bus.bus_dbg     = bus_val;

endmodule

// File: tb/tb_datapath_bus_unit.sv
// Directed plus randomized check of datapath_bus_unit against a register-level
// reference model. Registers are observed through the bus mux (bus_dbg).
`timescale 1ns/1ps
module tb_datapath_bus_unit;

    logic clk;
    logic rst;

    datapath_bus_unit_if #(.DATA_W(16), .ADDR_W(8), .OPC_W(6)) bus_if ();

    datapath_bus_unit #(.DATA_W(16), .ADDR_W(8), .OPC_W(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if.slave)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    int unsigned vectors;
    int unsigned miscompares;

    // reference model state
    bit [15:0] m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4;
    // inputs applied for the current cycle
    bit [3:0]  c_rd;
    bit [15:0] c_we, c_inc, c_clr, c_dm, c_im;
    bit [2:0]  c_op;
    bit        c_halt;

    logic [15:0] v;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit [15:0] model_bus(input bit [3:0] sel, input bit [15:0] dm, input bit [15:0] im);
        bit [15:0] src [16];
        src = '{16'h0, m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4,
                m_dr, dm, im, 16'h0, 16'h0};
        return src[sel];
    endfunction

    function automatic bit [15:0] model_alu(input bit [2:0] op);
        longint unsigned a, b, res;
        a = m_ac;
        b = m_r;
        case (op)
            3'd1:    res = a + b;
            3'd2:    res = a + 65536 - b;
            3'd3:    res = a * b;
            3'd4:    res = a << (b % 16);
            default: res = a;
        endcase
        return 16'(res % 65536);
    endfunction

    task automatic model_reset();
        {m_pc, m_ar, m_dr, m_ir, m_ac, m_r, m_r1, m_r2, m_r3, m_r4} = '0;
    endtask

    // Apply lowest-priority effects first so later ones override
    task automatic model_edge();
        bit [15:0] b, alu;
        if (c_halt) return;
        b   = model_bus(c_rd, c_dm, c_im);
        alu = model_alu(c_op);
        if (c_inc[1]) m_pc = m_pc + 16'd1;
        if (c_inc[4]) m_ac = m_ac + 16'd1;
        if (c_we[1])  m_pc = b;
        if (c_we[2])  m_ar = b;
        if (c_we[3])  m_ir = b;
        if (c_we[4])  m_ac = b;
        if (c_we[12]) m_ac = alu;
        if (c_we[5])  m_r  = b;
        if (c_we[7])  m_r4 = b;
        if (c_we[8])  m_r3 = b;
        if (c_we[9])  m_r2 = b;
        if (c_we[10]) m_r1 = b;
        if (c_clr[1]) m_pc = 16'd0;
        if (c_clr[2]) m_ar = 16'd0;
        if (c_clr[4]) m_ac = 16'd0;
    endtask

    task automatic check_status(input string pfx);
        check({pfx, "_im_addr"}, 16'(bus_if.im_addr), {8'h0, m_pc[7:0]});
        check({pfx, "_dm_addr"}, 16'(bus_if.dm_addr), {8'h0, m_ar[7:0]});
        check({pfx, "_instr"}, 16'(bus_if.instruction), {10'h0, m_ir[5:0]});
        check({pfx, "_z"}, bus_if.z, {15'b0, m_ac == 16'd0});
    endtask

    // Present one cycle's inputs on the falling edge, then check combinational outputs
    task automatic drive(input bit [3:0] rd, input bit [15:0] we, input bit [15:0] inc,
                         input bit [15:0] clr, input bit [2:0] op, input bit h,
                         input bit [15:0] dm, input bit [15:0] im);
        @(negedge clk);
        c_rd = rd; c_we = we; c_inc = inc; c_clr = clr; c_op = op; c_halt = h;
        c_dm = dm; c_im = im;
        bus_if.read_en  = rd;
        bus_if.write_en = we;
        bus_if.inc_en   = inc;
        bus_if.clr_en   = clr;
        bus_if.alu_op   = op;
        bus_if.halt     = h;
        bus_if.dm_rdata = dm;
        bus_if.im_rdata = im;
        #1;
        check("pre_bus", bus_if.bus_dbg, model_bus(rd, dm, im));
        check("pre_wdata", bus_if.dm_wdata, model_bus(rd, dm, im));
        check("pre_dm_we", 16'(bus_if.dm_we), {15'b0, we[11] & ~h});
        check_status("pre");
    endtask

    // Read every register back through the bus with strobes idle
    task automatic sweep(input string pfx);
        bus_if.write_en = '0;
        bus_if.inc_en   = '0;
        bus_if.clr_en   = '0;
        bus_if.halt     = 1'b0;
        for (int s = 0; s < 16; s++) begin
            bus_if.read_en = 4'(s);
            #1;
            check($sformatf("%s_src%0d", pfx, s), bus_if.bus_dbg,
                  model_bus(4'(s), bus_if.dm_rdata, bus_if.im_rdata));
        end
        check_status(pfx);
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        sweep("post");
    endtask

    task automatic peek(input bit [3:0] sel, output logic [15:0] val);
        bus_if.read_en = sel;
        #1;
        val = bus_if.bus_dbg;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vectors = 0;
        miscompares = 0;
        rst = 1'b1;
        bus_if.read_en = '0; bus_if.write_en = '0; bus_if.inc_en = '0; bus_if.clr_en = '0;
        bus_if.alu_op = '0; bus_if.halt = 1'b0; bus_if.dm_rdata = '0; bus_if.im_rdata = '0;
        model_reset();
        c_rd = '0; c_we = '0; c_inc = '0; c_clr = '0; c_op = '0; c_halt = 1'b0;
        c_dm = '0; c_im = '0;
        #3;
        check("rst_im_addr", 16'(bus_if.im_addr), 16'h0000);
        check("rst_dm_addr", 16'(bus_if.dm_addr), 16'h0000);
        check("rst_instr", 16'(bus_if.instruction), 16'h0000);
        check("rst_z", bus_if.z, 16'h0001);
        check("rst_dm_we", 16'(bus_if.dm_we), 16'h0000);
        #10 rst = 1'b0;

        // reset then fetch
        drive(4'd0, 16'h0000, 16'h0000, 16'h0006, 3'd0, 1'b0, 16'h0000, 16'h0000); tick();
        drive(4'd13, 16'h0008, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0013); tick();
        peek(4'd1, v); check("fetch_pc", v, 16'h0000);
        peek(4'd2, v); check("fetch_ar", v, 16'h0000);
        peek(4'd4, v); check("fetch_ir", v, 16'h0013);
        check("fetch_instr", 16'(bus_if.instruction), 16'h0013);
        check("fetch_z", bus_if.z, 16'h0001);

        // load and move
        drive(4'd5, 16'h0004, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000); tick();
        drive(4'd12, 16'h0010, 16'h0002, 16'h0000, 3'd0, 1'b0, 16'h0007, 16'h0000); tick();
        peek(4'd2, v); check("load_ar", v, 16'h0000);
        peek(4'd5, v); check("load_ac", v, 16'h0007);
        peek(4'd1, v); check("load_pc", v, 16'h0001);
        check("load_z", bus_if.z, 16'h0000);

        // ALU add, sub to zero, truncated multiply
        drive(4'd12, 16'h0020, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0003, 16'h0000); tick();
        drive(4'd0, 16'h1000, 16'h0000, 16'h0000, 3'd1, 1'b0, 16'h0000, 16'h0000); tick();
        peek(4'd5, v); check("alu_add", v, 16'h000A);
        drive(4'd12, 16'h0020, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h000A, 16'h0000); tick();
        drive(4'd0, 16'h1000, 16'h0000, 16'h0000, 3'd2, 1'b0, 16'h0000, 16'h0000); tick();
        peek(4'd5, v); check("alu_sub", v, 16'h0000);
        check("alu_sub_z", bus_if.z, 16'h0001);
        drive(4'd12, 16'h0030, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0100, 16'h0000); tick();
        drive(4'd0, 16'h1000, 16'h0000, 16'h0000, 3'd3, 1'b0, 16'h0000, 16'h0000); tick();
        peek(4'd5, v); check("alu_mul", v, 16'h0000);

        // jump beats increment
        drive(4'd13, 16'h0008, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0040); tick();
        drive(4'd12, 16'h0002, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0005, 16'h0000); tick();
        drive(4'd4, 16'h0002, 16'h0002, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000); tick();
        peek(4'd1, v); check("jump_pc", v, 16'h0040);

        // DM store, then halt
        drive(4'd12, 16'h0010, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h1234, 16'h0000); tick();
        drive(4'd12, 16'h0004, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0009, 16'h0000); tick();
        drive(4'd5, 16'h0800, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000);
        check("st_dm_we", 16'(bus_if.dm_we), 16'h0001);
        check("st_dm_addr", 16'(bus_if.dm_addr), 16'h0009);
        check("st_dm_wdata", bus_if.dm_wdata, 16'h1234);
        tick();
        drive(4'd12, 16'h0810, 16'h0012, 16'h0000, 3'd0, 1'b1, 16'h5555, 16'h0000);
        check("halt_dm_we", 16'(bus_if.dm_we), 16'h0000);
        tick();
        peek(4'd5, v); check("halt_ac", v, 16'h1234);
        peek(4'd1, v); check("halt_pc", v, 16'h0040);

        // randomized cycles against the model
        for (int i = 0; i < 200; i++) begin
            drive(4'($urandom_range(0, 15)), 16'($urandom),
                  16'($urandom), 16'($urandom & $urandom & $urandom),
                  3'($urandom_range(0, 7)), ($urandom_range(0, 7) == 0),
                  16'($urandom), 16'($urandom));
            tick();
        end

        // AC wrap, then reset between edges
        drive(4'd12, 16'h0410, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'hFFFF, 16'h0000); tick();
        drive(4'd0, 16'h0000, 16'h0010, 16'h0000, 3'd0, 1'b0, 16'h0000, 16'h0000); tick();
        peek(4'd5, v); check("wrap_ac", v, 16'h0000);
        check("wrap_z", bus_if.z, 16'h0001);
        peek(4'd7, v); check("wrap_r1", v, 16'hFFFF);
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        sweep("async_rst");
        @(negedge clk);
        rst = 1'b0;
        drive(4'd12, 16'h0010, 16'h0000, 16'h0000, 3'd0, 1'b0, 16'h00AB, 16'h0000); tick();
        peek(4'd5, v); check("post_rst_ac", v, 16'h00AB);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
